// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus responder: command encodings,
// violation codes, init sequence states and mode-register field positions.
package sdram_pkg;

    // {ras_n, cas_n, we_n} command encodings
    localparam logic [2:0] CMD_MRS   = 3'b000;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    // Violation codes reported on err_code (first one wins)
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BANK_IDLE    = 3'd1;
    localparam logic [2:0] ERR_BANK_ACTIVE  = 3'd2;
    localparam logic [2:0] ERR_TRCD         = 3'd3;
    localparam logic [2:0] ERR_BUS          = 3'd4;
    localparam logic [2:0] ERR_INIT         = 3'd5;
    localparam logic [2:0] ERR_MODE         = 3'd6;
    localparam logic [2:0] ERR_REF_INTERVAL = 3'd7;

    typedef enum logic [2:0] {
        INIT_WAIT_PALL,
        INIT_WAIT_REF1,
        INIT_WAIT_REF2,
        INIT_WAIT_MRS,
        INIT_READY
    } init_state_t;

    // Mode register / address field positions
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int AP_BIT      = 10;

    // Only CL 2/3 with burst length 1 is modelled
    function automatic logic mode_is_legal(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, latched open row and the tRCD
// down-counter that gates READ/WRITE after an ACT.
module sdram_resp_bank #(
    parameter int ROW_WIDTH = 13,
    parameter int T_RCD     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act,
    input  logic                 pre,
    input  logic [ROW_WIDTH-1:0] row_in,
    output logic                 active,
    output logic [ROW_WIDTH-1:0] open_row,
    output logic                 rcd_busy
);

    localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;

    logic                 active_reg, active_next;
    logic [ROW_WIDTH-1:0] row_reg, row_next;
    logic [RCD_W-1:0]     rcd_reg, rcd_next;

    // Next state: ACT only opens an idle bank; PRE (explicit or auto) closes it
    always_comb begin
        active_next = active_reg;
        row_next    = row_reg;
        rcd_next    = rcd_reg;
        if (rcd_reg != '0) begin
            rcd_next = rcd_reg - RCD_W'(1);
        end
        if (act && !active_reg) begin
            active_next = 1'b1;
            row_next    = row_in;
            rcd_next    = RCD_W'(T_RCD - 1);
        end else if (pre) begin
            active_next = 1'b0;
        end
    end

    // Bank state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            row_reg    <= '0;
            rcd_reg    <= '0;
        end else begin
            active_reg <= active_next;
            row_reg    <= row_next;
            rcd_reg    <= rcd_next;
        end
    end

    assign active   = active_reg;
    assign open_row = row_reg;
    assign rcd_busy = (rcd_reg != '0);

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device stand-in: decodes controller commands, tracks bank state,
// serves reads at the programmed CAS latency and latches the first protocol
// or timing violation. Build option SDRAM_RESP_REFRESH_CHECK_EN enables the
// maximum refresh interval check (code 7).
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH        = 13,
    parameter int COL_WIDTH        = 9,
    parameter int BANK_WIDTH       = 2,
    parameter int SDRADDR_WIDTH    = 13,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int T_RCD            = 2,
    parameter int T_RFC            = 7,
    parameter int MAX_REF_INTERVAL = 1040
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clock_enable,
    input  logic                     cs_n,
    input  logic                     ras_n,
    input  logic                     cas_n,
    input  logic                     we_n,
    input  logic [BANK_WIDTH-1:0]    bank_addr,
    input  logic [SDRADDR_WIDTH-1:0] addr,
    inout  wire  [15:0]              data,
    input  logic                     data_mask_low,
    input  logic                     data_mask_high,
    output logic                     init_done,
    output logic                     error,
    output logic [2:0]               err_code,
    output logic [15:0]              refresh_count
);

    localparam int NUM_BANKS = 2 ** BANK_WIDTH;
    localparam int RFC_W     = $clog2(T_RFC + 1);
    localparam int GAP_W     = $clog2(MAX_REF_INTERVAL + 1);
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
    localparam bit REF_CHECK_ON = 1'b1;
`else
    localparam bit REF_CHECK_ON = 1'b0;
`endif

    // Command decode (deselected or clock-disabled cycles look like NOP)
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       is_act, is_read, is_write, is_pre, is_ref, is_mrs, is_any;
    assign cmd_valid = clock_enable && !cs_n;
    assign cmd       = {ras_n, cas_n, we_n};
    assign is_act    = cmd_valid && (cmd == CMD_ACT);
    assign is_read   = cmd_valid && (cmd == CMD_READ);
    assign is_write  = cmd_valid && (cmd == CMD_WRITE);
    assign is_pre    = cmd_valid && (cmd == CMD_PRE);
    assign is_ref    = cmd_valid && (cmd == CMD_REF);
    assign is_mrs    = cmd_valid && (cmd == CMD_MRS);
    assign is_any    = is_act || is_read || is_write || is_pre || is_ref || is_mrs;

    // Bank array
    logic [NUM_BANKS-1:0] bank_active, bank_rcd_busy, bank_act, bank_pre;
    logic [ROW_WIDTH-1:0] bank_row [NUM_BANKS];
    logic                 sel_active, sel_busy, access_ok, auto_pre;
    logic [ROW_WIDTH-1:0] sel_row;
    assign sel_active = bank_active[bank_addr];
    assign sel_busy   = bank_rcd_busy[bank_addr];
    assign sel_row    = bank_row[bank_addr];
    assign auto_pre   = addr[AP_BIT];
    assign access_ok  = (is_read || is_write) && sel_active;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic hit;
            assign hit          = (bank_addr == BANK_WIDTH'(gi));
            assign bank_act[gi] = is_act && hit;
            assign bank_pre[gi] = (is_pre && (auto_pre || hit)) || (access_ok && auto_pre && hit);
            sdram_resp_bank #(
                .ROW_WIDTH(ROW_WIDTH),
                .T_RCD    (T_RCD)
            ) u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .act     (bank_act[gi]),
                .pre     (bank_pre[gi]),
                .row_in  (addr[ROW_WIDTH-1:0]),
                .active  (bank_active[gi]),
                .open_row(bank_row[gi]),
                .rcd_busy(bank_rcd_busy[gi])
            );
        end
    endgenerate

    // Backing store; index is the low bits of {bank, row, column}, aliasing on purpose
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic [15:0]               mem [2**MEM_ADDR_WIDTH];
    logic [15:0]               rd_word_reg;
    assign mem_idx = MEM_ADDR_WIDTH'({bank_addr, sel_row, addr[COL_WIDTH-1:0]});

    // Byte-masked write and registered read fetch on the command edge
    always_ff @(posedge clk) begin
        if (is_write && sel_active) begin
            if (!data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
            if (!data_mask_high) mem[mem_idx][15:8] <= data[15:8];
        end
        rd_word_reg <= mem[mem_idx];
    end

    // Read pipeline: stage 0 holds the fetched word, CL picks the stage to drive
    logic [2:0]  pipe_valid_reg;
    logic [15:0] pipe1_data_reg, pipe2_data_reg;
    logic [2:0]  cl_reg;
    logic        cl_is3, drive_en, read_pending;
    logic [15:0] drive_word;

    // Shift read pipeline; reset drops any in-flight data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
        end else begin
            pipe_valid_reg <= {pipe_valid_reg[1:0], is_read && sel_active};
        end
        pipe1_data_reg <= rd_word_reg;
        pipe2_data_reg <= pipe1_data_reg;
    end

    assign cl_is3       = (cl_reg == 3'd3);
    assign drive_en     = cl_is3 ? pipe_valid_reg[2] : pipe_valid_reg[1];
    assign drive_word   = cl_is3 ? pipe2_data_reg : pipe1_data_reg;
    assign read_pending = pipe_valid_reg[0] || pipe_valid_reg[1] || (cl_is3 && pipe_valid_reg[2]);
    assign data         = drive_en ? drive_word : 16'hzzzz;

    // Mode register fields
    logic [2:0] mode_cl, mode_bl;
    logic       mode_ok;
    assign mode_cl = addr[MODE_CL_MSB:MODE_CL_LSB];
    assign mode_bl = addr[MODE_BL_MSB:MODE_BL_LSB];
    assign mode_ok = mode_is_legal(mode_cl, mode_bl);

    // Refresh bookkeeping: tRFC lockout, REF counter, interval since last REF
    logic [RFC_W-1:0] rfc_reg;
    logic [GAP_W-1:0] ref_gap_reg;
    logic [15:0]      refresh_count_reg;
    logic             ref_overdue;
    init_state_t      state_reg, state_next;

    // CAS latency, refresh counters and interval timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cl_reg            <= 3'd3;
            rfc_reg           <= '0;
            refresh_count_reg <= '0;
            ref_gap_reg       <= '0;
        end else begin
            if (is_mrs && mode_ok) cl_reg <= mode_cl;
            if (is_ref) begin
                rfc_reg           <= RFC_W'(T_RFC);
                refresh_count_reg <= refresh_count_reg + 16'd1;
            end else if (rfc_reg != '0) begin
                rfc_reg <= rfc_reg - RFC_W'(1);
            end
            if (is_ref) begin
                ref_gap_reg <= '0;
            end else if (state_reg == INIT_READY && ref_gap_reg != GAP_W'(MAX_REF_INTERVAL)) begin
                ref_gap_reg <= ref_gap_reg + GAP_W'(1);
            end
        end
    end
    assign ref_overdue = REF_CHECK_ON && (ref_gap_reg == GAP_W'(MAX_REF_INTERVAL));

    // Init sequence: each state waits for one specific command; NOPs always fine
    logic init_viol;
    always_comb begin
        state_next = state_reg;
        init_viol  = 1'b0;
        if (is_any) begin
            case (state_reg)
                INIT_WAIT_PALL: if (is_pre && auto_pre) state_next = INIT_WAIT_REF1; else init_viol = 1'b1;
                INIT_WAIT_REF1: if (is_ref) state_next = INIT_WAIT_REF2; else init_viol = 1'b1;
                INIT_WAIT_REF2: if (is_ref) state_next = INIT_WAIT_MRS;  else init_viol = 1'b1;
                INIT_WAIT_MRS:  if (is_mrs) state_next = INIT_READY;     else init_viol = 1'b1;
                default: ;
            endcase
        end
    end

    // Init state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= INIT_WAIT_PALL;
        else        state_reg <= state_next;
    end

    // Violation classification for this cycle's command
    logic       viol;
    logic [2:0] viol_code;
    always_comb begin
        viol      = 1'b1;
        viol_code = ERR_NONE;
        if (init_viol)                                   viol_code = ERR_INIT;
        else if (is_any && rfc_reg != '0)                viol_code = ERR_BUS;
        else if (is_ref && (bank_active != '0))          viol_code = ERR_BUS;
        else if (is_mrs && !mode_ok)                     viol_code = ERR_MODE;
        else if (is_act && sel_active)                   viol_code = ERR_BANK_ACTIVE;
        else if ((is_read || is_write) && !sel_active)   viol_code = ERR_BANK_IDLE;
        else if ((is_read || is_write) && sel_busy)      viol_code = ERR_TRCD;
        else if (is_write && read_pending)               viol_code = ERR_BUS;
        else if (ref_overdue)                            viol_code = ERR_REF_INTERVAL;
        else                                             viol      = 1'b0;
    end

    // Sticky error flag holding the first violation code
    logic       error_reg;
    logic [2:0] err_code_reg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error_reg    <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else if (!error_reg && viol) begin
            error_reg    <= 1'b1;
            err_code_reg <= viol_code;
        end
    end

    assign init_done     = (state_reg == INIT_READY);
    assign error         = error_reg;
    assign err_code      = err_code_reg;
    assign refresh_count = refresh_count_reg;

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder: a transaction-level model (open rows,
// word memory keyed by aliased index, expected read-data timeline) checks DQ
// every cycle, plus directed init, byte-mask, violation and reset scenarios.
module tb_sdram_responder;

    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;
    localparam int T_RCD = 2;
    localparam int T_RFC = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clock_enable = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  bank_addr = '0;
    logic [12:0] addr = '0;
    wire  [15:0] data;
    logic        data_mask_low = 1'b0, data_mask_high = 1'b0;
    logic        init_done, error;
    logic [2:0]  err_code;
    logic [15:0] refresh_count;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;

    assign data = tb_oe ? tb_dq : 16'hzzzz;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pu
            pullup (data[gi]);
        end
    endgenerate

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .bank_addr(bank_addr), .addr(addr), .data(data),
        .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
        .init_done(init_done), .error(error), .err_code(err_code),
        .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_no = 0;
    int          cl = 3;
    int          ref_cnt = 0;
    int          last_read = -100;
    bit          z_check_on = 1'b1;
    bit          open_m [4];
    int          row_m [4];
    int          act_edge [4];
    bit          exp_v [16];
    logic [15:0] exp_d [16];
    logic [15:0] mem_m [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h edge=%0d", tag, got, want, edge_no);
        end
    endtask

    function automatic int mem_index(input int b, input int r, input int c);
        return (b * 4194304 + r * 512 + c) % 1024;
    endfunction

    // One clock: drive a command at negedge, then check DQ 1 ns after the edge
    task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [15:0] wd, input logic mlo, input logic mhi);
        int slot;
        @(negedge clk);
        cs_n = (c == C_NOP);
        {ras_n, cas_n, we_n} = c;
        bank_addr = b; addr = a;
        tb_oe = (c == C_WR); tb_dq = wd;
        data_mask_low = mlo; data_mask_high = mhi;
        @(posedge clk);
        #1;
        edge_no++;
        slot = edge_no % 16;
        if (exp_v[slot]) begin
            check("dq_read", data, exp_d[slot]);
            exp_v[slot] = 1'b0;
        end else if (z_check_on && !tb_oe) begin
            check("dq_z", data, 16'hFFFF);
        end
    endtask

    task automatic nop();
        tick(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 16; i++) exp_v[i] = 1'b0;
    endtask

    task automatic do_reset();
        clear_expect();
        rst_n = 1'b0;
        nop(); nop();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin open_m[i] = 1'b0; act_edge[i] = -100; end
        last_read = -100; cl = 3; ref_cnt = 0;
    endtask

    task automatic do_ref();
        tick(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
        ref_cnt++;
        repeat (T_RFC) nop();
    endtask

    task automatic do_init();
        tick(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0, 1'b0);
        do_ref();
        do_ref();
        tick(C_MRS, 2'd0, 13'h030, 16'd0, 1'b0, 1'b0);
        cl = 3;
        $display("INIT done edge=%0d", edge_no);
    endtask

    task automatic do_act(input int b, input int r);
        tick(C_ACT, 2'(b), 13'(r), 16'd0, 1'b0, 1'b0);
        open_m[b] = 1'b1; row_m[b] = r; act_edge[b] = edge_no;
        $display("ACT  bank=%0d row=%0h", b, r);
    endtask

    task automatic do_pre(input int b, input bit all);
        tick(C_PRE, 2'(b), all ? 13'h400 : 13'h000, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) if (all || i == b) open_m[i] = 1'b0;
        $display("PRE  bank=%0d all=%0d", b, all);
    endtask

    task automatic wait_rcd(input int b);
        while (edge_no + 1 - act_edge[b] < T_RCD) nop();
    endtask

    task automatic do_write(input int b, input int col, input logic [15:0] d,
                            input logic mlo, input logic mhi, input bit ap);
        int idx;
        logic [15:0] old_w;
        wait_rcd(b);
        while (edge_no + 1 - last_read <= cl) nop();
        tick(C_WR, 2'(b), (ap ? 13'h400 : 13'h000) | 13'(col), d, mlo, mhi);
        idx = mem_index(b, row_m[b], col);
        old_w = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
        mem_m[idx] = {mhi ? old_w[15:8] : d[15:8], mlo ? old_w[7:0] : d[7:0]};
        if (ap) open_m[b] = 1'b0;
        $display("WR   bank=%0d row=%0h col=%0h d=%04h mask=%0d%0d ap=%0d", b, row_m[b], col, d, mhi, mlo, ap);
    endtask

    task automatic do_read(input int b, input int col, input bit ap);
        int idx, due;
        wait_rcd(b);
        idx = mem_index(b, row_m[b], col);
        due = edge_no + 1 + cl - 1;
        exp_v[due % 16] = 1'b1;
        exp_d[due % 16] = mem_m[idx];
        tick(C_RD, 2'(b), (ap ? 13'h400 : 13'h000) | 13'(col), 16'd0, 1'b0, 1'b0);
        last_read = edge_no;
        if (ap) open_m[b] = 1'b0;
        $display("RD   bank=%0d row=%0h col=%0h exp=%04h ap=%0d", b, row_m[b], col, mem_m[idx], ap);
    endtask

    task automatic random_phase(input int n);
        int b, col, sel, idx;
        logic [15:0] d;
        logic mlo, mhi;
        for (int i = 0; i < n; i++) begin
            b = $urandom_range(0, 3);
            if (!open_m[b]) begin
                do_act(b, $urandom_range(0, 3));
            end else begin
                sel = $urandom_range(0, 11);
                col = $urandom_range(0, 15);
                idx = mem_index(b, row_m[b], col);
                if (sel == 0) begin
                    do_pre(b, 1'b0);
                end else if (sel == 1) begin
                    do_pre(0, 1'b1);
                    do_ref();
                end else if (sel < 6 || !mem_m.exists(idx)) begin
                    d = 16'($urandom);
                    mlo = mem_m.exists(idx) && ($urandom_range(0, 3) == 0);
                    mhi = mem_m.exists(idx) && ($urandom_range(0, 3) == 0);
                    do_write(b, col, d, mlo, mhi, $urandom_range(0, 7) == 0);
                end else begin
                    do_read(b, col, $urandom_range(0, 5) == 0);
                end
            end
        end
        repeat (4) nop();
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        check({tag, "_error"}, error, 1'b1);
        check({tag, "_code"}, err_code, code);
        $display("VIOL %s err_code=%0d", tag, err_code);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout edge=%0d", edge_no);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_init_done", init_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_code", err_code, 3'd0);
        check("rst_refresh_count", refresh_count, 16'd0);

        // Init sequence
        do_init();
        check("init_done", init_done, 1'b1);
        check("init_error", error, 1'b0);
        check("init_refresh_count", refresh_count, 16'd2);

        // Directed write/read with auto-precharge, then bank must accept ACT again
        do_act(1, 13'h0012);
        do_write(1, 5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        nop();
        do_read(1, 5, 1'b1);
        repeat (3) nop();
        do_act(1, 13'h0012);
        check("ap_bank_idle_error", error, 1'b0);

        // Byte mask: high byte preserved
        do_write(1, 6, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        do_write(1, 6, 16'h1234, 1'b0, 1'b1, 1'b0);
        do_read(1, 6, 1'b0);
        check("mask_model", mem_m[mem_index(1, 18, 6)], 16'hFF34);
        repeat (4) nop();

        // Randomized traffic at CL=3, then CL=2
        random_phase(150);
        check("rand3_error", error, 1'b0);
        tick(C_MRS, 2'd0, 13'h020, 16'd0, 1'b0, 1'b0);
        cl = 2;
        random_phase(150);
        check("rand2_error", error, 1'b0);
        check("rand_refresh_count", refresh_count, 16'(ref_cnt));

        // READ to idle bank, then ACT to active bank keeps first code
        z_check_on = 1'b0;
        do_reset(); do_init();
        tick(C_RD, 2'd2, 13'd3, 16'd0, 1'b0, 1'b0);
        expect_err("rd_idle", 3'd1);
        do_act(0, 1);
        tick(C_ACT, 2'd0, 13'd2, 16'd0, 1'b0, 1'b0);
        expect_err("act_active_sticky", 3'd1);

        // tRCD violation
        do_reset(); do_init();
        do_act(0, 1);
        tick(C_RD, 2'd0, 13'd1, 16'd0, 1'b0, 1'b0);
        expect_err("trcd", 3'd3);

        // REF with a bank open
        do_reset(); do_init();
        do_act(3, 2);
        tick(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
        expect_err("ref_open", 3'd4);

        // Command before init completes
        do_reset();
        tick(C_ACT, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
        expect_err("pre_init", 3'd5);
        check("pre_init_done", init_done, 1'b0);

        // WRITE while read data pending
        do_reset(); do_init();
        do_act(0, 1);
        do_write(0, 2, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        do_read(0, 2, 1'b0);
        tick(C_WR, 2'd0, 13'd3, 16'hAAAA, 1'b0, 1'b0);
        mem_m.delete(mem_index(0, 1, 3));
        expect_err("wr_contention", 3'd4);
        repeat (4) nop();

        // Illegal mode: code 6 and CL stays 3 (checked through read timing)
        z_check_on = 1'b1;
        do_reset(); do_init();
        tick(C_MRS, 2'd0, 13'h010, 16'd0, 1'b0, 1'b0);
        expect_err("bad_mode", 3'd6);
        do_act(2, 7);
        do_write(2, 9, 16'hC3A5, 1'b0, 1'b0, 1'b0);
        do_read(2, 9, 1'b1);
        repeat (4) nop();

        // Reset one cycle after READ at CL=2: DQ must be released on that edge
        do_reset(); do_init();
        tick(C_MRS, 2'd0, 13'h020, 16'd0, 1'b0, 1'b0);
        cl = 2;
        do_act(1, 3);
        do_write(1, 4, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        do_read(1, 4, 1'b0);
        clear_expect();
        rst_n = 1'b0;
        nop();
        check("midrd_init_done", init_done, 1'b0);
        check("midrd_refresh_count", refresh_count, 16'd0);
        check("midrd_error", error, 1'b0);
        rst_n = 1'b1;
        repeat (3) nop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
